alu_seq_param: RTL

//  Width-parametrised, handshaked successor of the 32-bit combinational ALU.

---
 rtl/alu_seq_param.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_param.sv
// Handshaked, width-parametrised ALU with iterative shifts and registered NZCV flags.
// One op in flight: IDLE accepts, SHIFT iterates shifts, DONE holds the result until consumed.
module alu_seq_param #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         inp_A,
    input  logic [WIDTH-1:0]         inp_B,
    input  logic [2:0]               select,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out,
    output logic                     flag_z,
    output logic                     flag_n,
    output logic                     flag_c,
    output logic                     flag_v
);

    localparam int unsigned SW       = $clog2(WIDTH);
    // shamt never exceeds WIDTH-1, so larger steps behave like WIDTH-1
    localparam int unsigned STEP_CAP = (SHIFT_STEP >= WIDTH) ? WIDTH - 1 : SHIFT_STEP;
    localparam logic [SW-1:0] STEP_K = SW'(STEP_CAP);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             in_ready_d;
    logic             out_valid_d;

    logic [WIDTH-1:0] sh;
    logic [SW-1:0]    cnt;
    logic             sra_op;

    logic             is_shift_in;
    logic             accept;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    logic [SW-1:0]        k;
    logic [WIDTH:0]       sll_ext;
    logic signed [WIDTH:0] sra_ext;
    logic [WIDTH-1:0]     shift_res;
    logic                 shift_c;

    assign is_shift_in = (select == OP_SRA) || (select == OP_SLL);
    assign accept      = in_valid && in_ready;

    // Single-cycle ops; shifts pass A through here so shamt=0 needs no special path
    assign add_ext = {1'b0, inp_A} + {1'b0, inp_B};
    assign sub_ext = {1'b0, inp_A} + {1'b0, ~inp_B} + (WIDTH+1)'(1);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (select)
            OP_AND: alu_res = inp_A & inp_B;
            OP_OR:  alu_res = inp_A | inp_B;
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (inp_A[WIDTH-1] == inp_B[WIDTH-1]) &&
                          (add_ext[WIDTH-1] != inp_A[WIDTH-1]);
            end
            OP_XOR: alu_res = inp_A ^ inp_B;
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (inp_A[WIDTH-1] != inp_B[WIDTH-1]) &&
                          (sub_ext[WIDTH-1] != inp_A[WIDTH-1]);
            end
            OP_SRA, OP_SLL: alu_res = inp_A;
            OP_NOR: alu_res = ~(inp_A | inp_B);
            default: alu_res = '0;
        endcase
    end

    // One iteration of the shifter; the extra bit catches the last bit shifted out
    assign k         = (cnt > STEP_K) ? STEP_K : cnt;
    assign sll_ext   = {1'b0, sh} << k;
    assign sra_ext   = $signed({sh, 1'b0}) >>> k;
    assign shift_res = sra_op ? sra_ext[WIDTH:1] : sll_ext[WIDTH-1:0];
    assign shift_c   = sra_op ? sra_ext[0] : sll_ext[WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (is_shift_in && (shamt != '0)) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (cnt == k) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        in_ready_d  = (state_next == S_IDLE);
        out_valid_d = (state_next == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh     <= '0;
            cnt    <= '0;
            sra_op <= 1'b0;
            out    <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sra_op <= (select == OP_SRA);
                        if (is_shift_in && (shamt != '0)) begin
                            sh  <= inp_A;
                            cnt <= shamt;
                        end else begin
                            out    <= alu_res;
                            flag_z <= (alu_res == '0);
                            flag_n <= alu_res[WIDTH-1];
                            flag_c <= alu_c;
                            flag_v <= alu_v;
                        end
                    end
                end
                S_SHIFT: begin
                    sh  <= shift_res;
                    cnt <= cnt - k;
                    if (cnt == k) begin
                        out    <= shift_res;
                        flag_z <= (shift_res == '0);
                        flag_n <= shift_res[WIDTH-1];
                        flag_c <= shift_c;
                        flag_v <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
